// File: rtl/spi_reg_bank_if.sv
// -----------------------------------------------------------------------------
// spi_reg_bank_if
// Four-wire SPI bus bundle shared by the board-control SPI master and the
// addressed slaves hanging off it.
//   sclk : SPI clock (mode 0, idles low)
//   cs   : chip select, active low
//   mosi : master-to-slave data, MSB first
//   miso : slave-to-master data, MSB first
// Modports:
//   master : drives sclk/cs/mosi, receives miso
//   slave  : receives sclk/cs/mosi, drives miso
// -----------------------------------------------------------------------------
interface spi_reg_bank_if;
   logic sclk;
   logic cs;
   logic mosi;
   logic miso;

   modport master (output sclk, output cs, output mosi, input miso);
   modport slave  (input sclk, input cs, input mosi, output miso);
endinterface

// File: rtl/spi_reg_bank.sv
// -----------------------------------------------------------------------------
// spi_reg_bank
// SPI-slave register bank: NREG registers of Nbit bits mapped at BASE_ADR on
// the board-control SPI bus. A frame starts with an 8-bit header {r_w, a[6:0]}
// (r_w = 1 writes, r_w = 0 reads), followed by Nbit-bit data words. The
// address auto-increments per word; running past the last register silences
// the slave for the rest of the frame. Every committed write emits a one-clk
// strobe with the register index.
// Ports:
//   clk    : system clock, all logic on posedge
//   rst    : asynchronous active-low reset
//   spi    : SPI bus (slave modport), asynchronous to clk
//   out    : register contents, register i at [i*Nbit +: Nbit]
//   wr_stb : one-clk pulse per committed register write
//   wr_idx : index of the register written, valid with wr_stb
// -----------------------------------------------------------------------------
module spi_reg_bank #(
   parameter int              Nbit     = 8,
   parameter int              NREG     = 4,
   parameter logic [6:0]      BASE_ADR = 7'h10,
   parameter logic [Nbit-1:0] RST_VAL  = '0
) (
   input  logic                 clk,
   input  logic                 rst,
   spi_reg_bank_if.slave        spi,
   output logic [NREG*Nbit-1:0] out,
   output logic                 wr_stb,
   output logic [3:0]           wr_idx
);

   localparam int CW = $clog2(Nbit) + 1;

   typedef enum logic [2:0] {IDLE, ADDR, WR, RD, SKIP} state_t;

   state_t          state_reg, state_next;
   logic [CW-1:0]   cnt_reg, cnt_next;
   logic [3:0]      idx_reg, idx_next;
   logic [Nbit-2:0] rx_reg, rx_next;     // bits received so far; the last bit comes straight from the synchroniser
   logic [Nbit-1:0] tx_reg, tx_next;
   logic [Nbit-1:0] regs_reg [NREG];
   logic            wr_stb_reg;
   logic [3:0]      wr_idx_reg;
   logic            commit;

   // ---------------------------------------------------------------------------
   // Synchronisers. Bit 0 is the first flop; edges are taken between the
   // second and third stage so every edge lasts exactly one clk.
   // cs resets to 0 so that a reset released while cs is already low does not
   // look like a fresh frame start.
   // ---------------------------------------------------------------------------
   logic [2:0] sclk_sync_reg;
   logic [2:0] cs_sync_reg;
   logic [1:0] mosi_sync_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sclk_sync_reg <= '0;
         cs_sync_reg   <= '0;
         mosi_sync_reg <= '0;
      end else begin
         sclk_sync_reg <= {sclk_sync_reg[1:0], spi.sclk};
         cs_sync_reg   <= {cs_sync_reg[1:0], spi.cs};
         mosi_sync_reg <= {mosi_sync_reg[0], spi.mosi};
      end
   end

   logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_bit;

   assign sclk_rise = sclk_sync_reg[1] & ~sclk_sync_reg[2];
   assign sclk_fall = ~sclk_sync_reg[1] & sclk_sync_reg[2];
   assign cs_rise   = cs_sync_reg[1] & ~cs_sync_reg[2];
   assign cs_fall   = ~cs_sync_reg[1] & cs_sync_reg[2];
   assign mosi_bit  = mosi_sync_reg[1];

   // ---------------------------------------------------------------------------
   // Header decode, evaluated with the bit arriving on the current rise.
   // ---------------------------------------------------------------------------
   logic [Nbit-1:0] word;
   logic [7:0]      header;
   logic [7:0]      adr_off;
   logic            adr_hit;
   logic [3:0]      hit_idx;
   logic [3:0]      idx_inc;
   logic            idx_past_end;

   assign word    = {rx_reg, mosi_bit};
   assign header  = word[7:0];
   assign adr_off = {1'b0, header[6:0]} - {1'b0, BASE_ADR};
   // The lower-bound test guards against the subtraction wrapping.
   assign adr_hit = ({1'b0, header[6:0]} >= {1'b0, BASE_ADR}) && (adr_off < 8'(NREG));
   assign hit_idx = adr_off[3:0];
   assign idx_inc = idx_reg + 4'd1;
   assign idx_past_end = (({1'b0, idx_reg} + 5'd1) >= 5'(NREG));

   // Register read mux written as a loop so that index widths never have to
   // match the array depth; unmapped indices read as all ones.
   function automatic logic [Nbit-1:0] reg_at(input logic [3:0] i);
      logic [Nbit-1:0] v;
      v = '1;
      for (int k = 0; k < NREG; k++) begin
         if (i == 4'(k)) begin
            v = regs_reg[k];
         end
      end
      return v;
   endfunction

   // ---------------------------------------------------------------------------
   // FSM state register and datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         idx_reg   <= '0;
         rx_reg    <= '0;
         tx_reg    <= '1;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         idx_reg   <= idx_next;
         rx_reg    <= rx_next;
         tx_reg    <= tx_next;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state and datapath control
   // ---------------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      idx_next   = idx_reg;
      rx_next    = rx_reg;
      tx_next    = tx_reg;
      commit     = 1'b0;

      if (cs_rise) begin
         // End of frame wins over any simultaneous sclk edge; a partial word
         // simply stays in rx_reg and is never committed.
         state_next = IDLE;
         cnt_next   = '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (cs_fall) begin
                  state_next = ADDR;
                  cnt_next   = '0;
               end
            end

            ADDR: begin
               if (sclk_rise) begin
                  rx_next  = word[Nbit-2:0];
                  cnt_next = cnt_reg + 1'b1;
                  if (cnt_reg == CW'(7)) begin
                     cnt_next = '0;
                     if (adr_hit) begin
                        idx_next = hit_idx;
                        if (header[7]) begin
                           state_next = WR;
                        end else begin
                           state_next = RD;
                           tx_next    = reg_at(hit_idx);
                        end
                     end else begin
                        state_next = SKIP;
                     end
                  end
               end
            end

            WR: begin
               if (sclk_rise) begin
                  rx_next  = word[Nbit-2:0];
                  cnt_next = cnt_reg + 1'b1;
                  if (cnt_reg == CW'(Nbit - 1)) begin
                     commit   = 1'b1;
                     cnt_next = '0;
                     // No wrap: writing the last register ends the burst.
                     if (idx_reg == 4'(NREG - 1)) begin
                        state_next = SKIP;
                     end else begin
                        idx_next = idx_inc;
                     end
                  end
               end
            end

            RD: begin
               // cnt counts rises of the current word. The fall right after
               // the header (cnt = 0) must not shift, or the MSB would be lost
               // before the master samples it.
               if (sclk_rise) begin
                  if (cnt_reg != CW'(Nbit)) begin
                     cnt_next = cnt_reg + 1'b1;
                  end
               end else if (sclk_fall && (cnt_reg != '0)) begin
                  if (cnt_reg == CW'(Nbit)) begin
                     cnt_next = '0;
                     if (idx_past_end) begin
                        tx_next    = '1;
                        state_next = SKIP;
                     end else begin
                        idx_next = idx_inc;
                        tx_next  = reg_at(idx_inc);
                     end
                  end else begin
                     tx_next = {tx_reg[Nbit-2:0], 1'b1};
                  end
               end
            end

            SKIP: begin
               // Wait for cs to rise; sclk is ignored.
            end

            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Register file and write strobe
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < NREG; k++) begin
            regs_reg[k] <= RST_VAL;
         end
         wr_stb_reg <= 1'b0;
         wr_idx_reg <= '0;
      end else begin
         for (int k = 0; k < NREG; k++) begin
            if (commit && (idx_reg == 4'(k))) begin
               regs_reg[k] <= word;
            end
         end
         wr_stb_reg <= commit;
         if (commit) begin
            wr_idx_reg <= idx_reg;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < NREG; gi++) begin : g_out
         assign out[gi*Nbit +: Nbit] = regs_reg[gi];
      end
   endgenerate

   assign wr_stb   = wr_stb_reg;
   assign wr_idx   = wr_idx_reg;
   assign spi.miso = (state_reg == RD) ? tx_reg[Nbit-1] : 1'b1;

endmodule

// File: tb/tb_spi_reg_bank.sv
// -----------------------------------------------------------------------------
// tb_spi_reg_bank
// Bench for spi_reg_bank (Nbit=8, NREG=4, BASE_ADR=7'h10, RST_VAL=8'hC3).
// A behavioural model computes, for each frame, the bytes the master should
// see on miso, the expected strobe indices and the resulting register image.
// -----------------------------------------------------------------------------
module tb_spi_reg_bank;

   localparam int         NB = 8;
   localparam int         NR = 4;
   localparam logic [7:0] RV = 8'hC3;
   localparam time        HP = 60ns;   // sclk half period (6 clk)

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5ns clk = ~clk;

   spi_reg_bank_if bus ();

   logic [NR*NB-1:0] out;
   logic             wr_stb;
   logic [3:0]       wr_idx;

   spi_reg_bank #(
      .Nbit     (NB),
      .NREG     (NR),
      .BASE_ADR (7'h10),
      .RST_VAL  (RV)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .spi    (bus),
      .out    (out),
      .wr_stb (wr_stb),
      .wr_idx (wr_idx)
   );

   int         n_assert = 0;
   int         n_fail   = 0;
   logic [7:0] mreg [NR];
   int         stb_q[$];
   int         exp_stb[$];
   logic [7:0] tx_q[$];
   logic [7:0] rx_q[$];
   logic [7:0] exp_rx[$];

   // Each clk with wr_stb high records one strobe, so a stretched pulse shows
   // up as an extra entry.
   always @(negedge clk) begin
      if (wr_stb === 1'b1) begin
         stb_q.push_back(int'(wr_idx));
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NR*NB-1:0] model_out();
      logic [NR*NB-1:0] v;
      for (int i = 0; i < NR; i++) begin
         v[i*NB +: NB] = mreg[i];
      end
      return v;
   endfunction

   // Reference model of one complete frame: header plus every byte in tx_q.
   task automatic model_frame(input logic [7:0] hdr);
      int a;
      int idx;
      bit hit;
      exp_rx.delete();
      exp_stb.delete();
      exp_rx.push_back(8'hFF);
      a   = int'(hdr[6:0]);
      hit = (a >= 'h10) && (a < 'h10 + NR);
      idx = a - 'h10;
      foreach (tx_q[i]) begin
         if (hit && hdr[7]) begin
            if (idx < NR) begin
               mreg[idx] = tx_q[i];
               exp_stb.push_back(idx);
            end
            idx++;
            exp_rx.push_back(8'hFF);
         end else if (hit) begin
            exp_rx.push_back((idx < NR) ? mreg[idx] : 8'hFF);
            idx++;
         end else begin
            exp_rx.push_back(8'hFF);
         end
      end
   endtask

   // Mode 0 master: mosi set while sclk is low, miso sampled at the rise.
   task automatic spi_bits(input logic [7:0] v, input int n, output logic [7:0] r);
      r = '0;
      for (int b = 0; b < n; b++) begin
         bus.mosi = v[7-b];
         #HP;
         r = {r[6:0], bus.miso};
         bus.sclk = 1'b1;
         #HP;
         bus.sclk = 1'b0;
      end
   endtask

   task automatic cs_low();
      bus.cs = 1'b0;
      #HP;
   endtask

   task automatic cs_high();
      #HP;
      bus.cs = 1'b1;
      #(HP * 2);
   endtask

   task automatic run_frame(input logic [7:0] hdr);
      logic [7:0] r;
      model_frame(hdr);
      cs_low();
      spi_bits(hdr, 8, r);
      rx_q.push_back(r);
      foreach (tx_q[i]) begin
         spi_bits(tx_q[i], 8, r);
         rx_q.push_back(r);
      end
      cs_high();
   endtask

   task automatic check_frame(input string tag);
      foreach (rx_q[i]) begin
         chk($sformatf("%s miso byte %0d", tag, i), 64'(rx_q[i]), 64'(exp_rx[i]));
      end
      chk($sformatf("%s strobe count", tag), 64'(stb_q.size()), 64'(exp_stb.size()));
      for (int i = 0; i < stb_q.size() && i < exp_stb.size(); i++) begin
         chk($sformatf("%s strobe idx %0d", tag, i), 64'(stb_q[i]), 64'(exp_stb[i]));
      end
      chk($sformatf("%s registers", tag), 64'(out), 64'(model_out()));
      rx_q.delete();
      stb_q.delete();
      tx_q.delete();
   endtask

   initial begin
      logic [7:0] r;
      logic [7:0] hdr;
      int         nw;

      bus.cs   = 1'b1;
      bus.sclk = 1'b0;
      bus.mosi = 1'b0;
      for (int i = 0; i < NR; i++) mreg[i] = RV;

      // Reset state
      repeat (4) @(posedge clk);
      #1;
      chk("reset out", 64'(out), 64'({NR{RV}}));
      chk("reset miso", 64'(bus.miso), 64'(1'b1));
      chk("reset wr_stb", 64'(wr_stb), 64'(1'b0));
      chk("reset wr_idx", 64'(wr_idx), 64'(4'd0));
      rst = 1'b1;
      repeat (5) @(posedge clk);
      stb_q.delete();

      // Single write to register 1
      tx_q = '{8'hA5};
      run_frame(8'h91);
      check_frame("single write");

      // Burst write running off the end of the bank
      tx_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      run_frame(8'h90);
      check_frame("burst write");

      // Read-back from register 2: 33, 44, then all ones
      tx_q = '{8'($urandom), 8'($urandom), 8'($urandom)};
      run_frame(8'h12);
      check_frame("read back");

      // Address miss
      tx_q = '{8'h00};
      run_frame(8'h85);
      check_frame("address miss");

      // Abort after 5 data bits
      cs_low();
      spi_bits(8'h90, 8, r);
      spi_bits(8'h5C, 5, r);
      cs_high();
      chk("abort strobe count", 64'(stb_q.size()), 64'(0));
      chk("abort registers", 64'(out), 64'(model_out()));
      stb_q.delete();

      // Next full frame after the abort writes normally
      tx_q = '{8'h6E};
      run_frame(8'h90);
      check_frame("post abort write");

      // Randomised frames around the address window
      for (int t = 0; t < 20; t++) begin
         hdr = {1'($urandom_range(0, 1)), 7'($urandom_range('h0E, 'h15))};
         nw  = $urandom_range(0, 5);
         for (int i = 0; i < nw; i++) tx_q.push_back(8'($urandom));
         run_frame(hdr);
         check_frame($sformatf("random %0d hdr %02h", t, hdr));
      end

      // Reset asserted in the middle of a burst
      cs_low();
      spi_bits(8'h90, 8, r);
      spi_bits(8'hE1, 8, r);
      spi_bits(8'hE2, 8, r);
      #HP;
      rst = 1'b0;
      #1;
      for (int i = 0; i < NR; i++) mreg[i] = RV;
      chk("mid reset out", 64'(out), 64'(model_out()));
      chk("mid reset miso", 64'(bus.miso), 64'(1'b1));
      chk("mid reset wr_stb", 64'(wr_stb), 64'(1'b0));
      repeat (3) @(posedge clk);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      stb_q.delete();
      // cs is still low: the rest of this frame must be ignored
      spi_bits(8'hE3, 8, r);
      chk("after reset miso", 64'(r), 64'(8'hFF));
      spi_bits(8'hE4, 8, r);
      cs_high();
      chk("after reset strobe count", 64'(stb_q.size()), 64'(0));
      chk("after reset registers", 64'(out), 64'(model_out()));
      stb_q.delete();

      // A fresh frame is accepted again
      tx_q = '{8'h7A, 8'h3B};
      run_frame(8'h92);
      check_frame("post reset write");
      tx_q = '{8'h00, 8'h00, 8'h00, 8'h00};
      run_frame(8'h10);
      check_frame("final read");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
